// File: rtl/uart_banner_echo_ctrl_if.sv
// RX-to-TX byte path of the banner/echo controller: RX strobe, TX valid/ready, status flags.
// master = controller side, slave = UART RX/TX side.
interface uart_banner_echo_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       banner_act;
  logic       rx_ovf;

  modport master (
    input  rx_valid, rx_data, tx_ready,
    output tx_valid, tx_data, banner_act, rx_ovf
  );

  modport slave (
    output rx_valid, rx_data, tx_ready,
    input  tx_valid, tx_data, banner_act, rx_ovf
  );
endinterface

// File: rtl/uart_banner_echo_ctrl.sv
// Echoes RX bytes to TX through a one-entry buffer and sends a ROM banner after IDLE_CYCLES of RX silence.
// Define UART_BANNER_REPEAT_EN to resend the banner after every idle period; otherwise it goes out once per reset.
module uart_banner_echo_ctrl #(
  parameter int MSG_LEN     = 20,
  parameter int IDLE_CYCLES = 262143,
  parameter int CNT_W       = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  uart_banner_echo_ctrl_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_ECHO, S_BANNER} state_t;

  localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_CYCLES);
  localparam logic [4:0]       LAST_IDX = 5'(MSG_LEN - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_idle_cnt;
  logic [4:0]       r_idx;
  logic [7:0]       r_buf;
  logic             r_buf_vld;
  logic             r_tx_valid;
  logic [7:0]       r_tx_data;
  logic             r_banner_act;
  logic             r_rx_ovf;

  logic w_xfer;
  logic w_drain;
  logic w_abort;
  logic w_ban_en;

  // Positions past the text read as zero padding.
  function automatic logic [7:0] rom_byte(input logic [4:0] i);
    case (i)
      5'd0:    rom_byte = 8'h48;
      5'd1:    rom_byte = 8'h65;
      5'd2:    rom_byte = 8'h6C;
      5'd3:    rom_byte = 8'h6C;
      5'd4:    rom_byte = 8'h6F;
      5'd5:    rom_byte = 8'h20;
      5'd6:    rom_byte = 8'h41;
      5'd7:    rom_byte = 8'h4C;
      5'd8:    rom_byte = 8'h49;
      5'd9:    rom_byte = 8'h4E;
      5'd10:   rom_byte = 8'h58;
      5'd11:   rom_byte = 8'h20;
      5'd12:   rom_byte = 8'h41;
      5'd13:   rom_byte = 8'h4E;
      5'd14:   rom_byte = 8'h33;
      5'd15:   rom_byte = 8'h34;
      5'd16:   rom_byte = 8'h38;
      5'd17:   rom_byte = 8'h35;
      5'd18:   rom_byte = 8'h0A;
      5'd19:   rom_byte = 8'h0D;
      default: rom_byte = 8'h00;
    endcase
  endfunction

  assign w_xfer  = r_tx_valid & bus.tx_ready;
  assign w_drain = (r_state == S_ECHO) & w_xfer;
  assign w_abort = r_buf_vld | bus.rx_valid;

  assign bus.tx_valid   = r_tx_valid;
  assign bus.tx_data    = r_tx_data;
  assign bus.banner_act = r_banner_act;
  assign bus.rx_ovf     = r_rx_ovf;

`ifdef UART_BANNER_REPEAT_EN
  assign w_ban_en = 1'b1;
`else
  logic r_done;

  // Entering BANNER is enough to lock it out: IDLE only looks at this after the banner ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_done <= 1'b0;
    else if (r_state == S_BANNER) r_done <= 1'b1;
  end

  assign w_ban_en = ~r_done;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf     <= 8'h00;
      r_buf_vld <= 1'b0;
      r_rx_ovf  <= 1'b0;
    end else if (bus.rx_valid) begin
      if (!r_buf_vld || w_drain) begin
        r_buf     <= bus.rx_data;
        r_buf_vld <= 1'b1;
      end else begin
        r_rx_ovf  <= 1'b1;
      end
    end else if (w_drain) begin
      r_buf_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       r_idle_cnt <= '0;
    else if (bus.rx_valid || (r_state != S_IDLE))  r_idle_cnt <= '0;
    else if (r_idle_cnt != IDLE_MAX)               r_idle_cnt <= r_idle_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= 5'd0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= 8'h00;
      r_banner_act <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx_valid <= 1'b0;
          if (r_buf_vld) begin
            r_state    <= S_ECHO;
            r_tx_valid <= 1'b1;
            r_tx_data  <= r_buf;
          end else if ((r_idle_cnt == IDLE_MAX) && !bus.rx_valid && w_ban_en) begin
            r_state      <= S_BANNER;
            r_banner_act <= 1'b1;
            r_idx        <= 5'd0;
          end
        end

        // A same-edge RX reload keeps us here; the gap cycle then re-presents the buffer.
        S_ECHO: begin
          if (w_xfer) begin
            r_tx_valid <= 1'b0;
            if (!bus.rx_valid) r_state <= S_IDLE;
          end else if (!r_tx_valid) begin
            if (r_buf_vld) begin
              r_tx_valid <= 1'b1;
              r_tx_data  <= r_buf;
            end else begin
              r_state    <= S_IDLE;
            end
          end
        end

        S_BANNER: begin
          if (r_tx_valid) begin
            if (w_xfer) begin
              r_tx_valid <= 1'b0;
              if (w_abort) begin
                r_state      <= S_ECHO;
                r_banner_act <= 1'b0;
                r_idx        <= 5'd0;
              end else if (r_idx == LAST_IDX) begin
                r_state      <= S_IDLE;
                r_banner_act <= 1'b0;
                r_idx        <= 5'd0;
              end else begin
                r_idx        <= r_idx + 5'd1;
              end
            end
          end else if (w_abort) begin
            r_state      <= S_ECHO;
            r_banner_act <= 1'b0;
            r_idx        <= 5'd0;
          end else begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= rom_byte(r_idx);
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_tx_valid   <= 1'b0;
          r_banner_act <= 1'b0;
          r_idx        <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_banner_echo_ctrl.sv
// Directed bench for uart_banner_echo_ctrl with MSG_LEN=20, IDLE_CYCLES=100.
`timescale 1ns/1ps
module tb_uart_banner_echo_ctrl;
  localparam int MSG_LEN     = 20;
  localparam int IDLE_CYCLES = 100;
  localparam int CNT_W       = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_banner_echo_ctrl_if bus();

  uart_banner_echo_ctrl #(
    .MSG_LEN(MSG_LEN), .IDLE_CYCLES(IDLE_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] rom_exp [MSG_LEN] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h41, 8'h4C, 8'h49, 8'h4E,
                                    8'h58, 8'h20, 8'h41, 8'h4E, 8'h33, 8'h34, 8'h38, 8'h35, 8'h0A, 8'h0D};
  logic [7:0] txq  [$];
  logic [7:0] expq [$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_txq(input string tag);
    check({tag, "_len"}, 32'(txq.size()), 32'(expq.size()));
    foreach (expq[i])
      check($sformatf("%s_b%0d", tag, i), (i < txq.size()) ? 32'(txq[i]) : 32'hFFFF_FFFF, 32'(expq[i]));
  endtask

  task automatic wait_vld(input string tag, input int max, output int cyc);
    cyc = 0;
    while (!bus.tx_valid && cyc < max) begin
      tick();
      cyc++;
    end
    check({tag, "_seen"}, 32'(bus.tx_valid), 32'd1);
  endtask

  task automatic wait_byte(input string tag, input logic [7:0] val, input int max);
    int cyc = 0;
    while (!(bus.tx_valid && bus.tx_data == val) && cyc < max) begin
      tick();
      cyc++;
    end
    check({tag, "_seen"}, 32'(bus.tx_valid && bus.tx_data == val), 32'd1);
  endtask

  task automatic rx_byte(input logic [7:0] d);
    bus.rx_valid = 1'b1;
    bus.rx_data  = d;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Transfer logger plus gap/hold protocol checks, sampled mid-cycle.
  initial begin
    logic       prev_xfer = 1'b0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_dat  = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_xfer = 1'b0;
        prev_hold = 1'b0;
      end else begin
        if (prev_xfer) check("gap_after_xfer", 32'(bus.tx_valid), 32'd0);
        if (prev_hold) begin
          check("hold_vld", 32'(bus.tx_valid), 32'd1);
          check("hold_dat", 32'(bus.tx_data), 32'(prev_dat));
        end
        prev_xfer = bus.tx_valid && bus.tx_ready;
        prev_hold = bus.tx_valid && !bus.tx_ready;
        prev_dat  = bus.tx_data;
        if (prev_xfer) txq.push_back(bus.tx_data);
      end
    end
  end

  initial begin
    int cyc;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b1;

    // Reset values
    tick();
    tick();
    check("rst_tx_valid",   32'(bus.tx_valid),   32'd0);
    check("rst_tx_data",    32'(bus.tx_data),    32'h00);
    check("rst_banner_act", 32'(bus.banner_act), 32'd0);
    check("rst_rx_ovf",     32'(bus.rx_ovf),     32'd0);

    // First banner after 100 silent cycles
    rst = 1'b0;
    txq.delete();
    wait_vld("ban1", 200, cyc);
    check("ban1_latency",  32'(cyc),            32'd102);
    check("ban1_first",    32'(bus.tx_data),    32'h48);
    check("ban1_act",      32'(bus.banner_act), 32'd1);
    for (int i = 1; i <= 38; i++) begin
      tick();
      check($sformatf("ban1_act_c%0d", i), 32'(bus.banner_act), 32'd1);
    end
    repeat (3) tick();
    check("ban1_act_end", 32'(bus.banner_act), 32'd0);
    expq.delete();
    foreach (rom_exp[i]) expq.push_back(rom_exp[i]);
    check_txq("ban1");

    // Echo latency from IDLE
    txq.delete();
    rx_byte(8'h5A);
    check("echo_n1_vld", 32'(bus.tx_valid),   32'd0);
    tick();
    check("echo_n2_vld", 32'(bus.tx_valid),   32'd1);
    check("echo_n2_dat", 32'(bus.tx_data),    32'h5A);
    check("echo_n2_act", 32'(bus.banner_act), 32'd0);
    repeat (3) tick();
    expq = '{8'h5A};
    check_txq("echo");

    // Silence after the banner: one-shot unless repeat is built in
    txq.delete();
    repeat (160) tick();
    expq.delete();
`ifdef UART_BANNER_REPEAT_EN
    foreach (rom_exp[i]) expq.push_back(rom_exp[i]);
`endif
    check_txq("silence");

    // Abort during idx5, echo follows, no resume
    do_reset();
    txq.delete();
    wait_byte("abort_idx5", 8'h20, 200);
    rx_byte(8'h31);
    repeat (10) tick();
    expq = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h31};
    check_txq("abort");
    check("abort_act", 32'(bus.banner_act), 32'd0);

    // Backpressured echo with overflow
    do_reset();
    txq.delete();
    bus.tx_ready = 1'b0;
    rx_byte(8'hA5);
    tick();
    check("ovf_pre_vld", 32'(bus.tx_valid), 32'd1);
    check("ovf_pre_dat", 32'(bus.tx_data),  32'hA5);
    check("ovf_pre_flag", 32'(bus.rx_ovf),  32'd0);
    for (int i = 0; i < 50; i++) begin
      if (i == 10) rx_byte(8'h11);
      else tick();
    end
    check("ovf_flag",     32'(bus.rx_ovf),   32'd1);
    check("ovf_hold_vld", 32'(bus.tx_valid), 32'd1);
    check("ovf_hold_dat", 32'(bus.tx_data),  32'hA5);
    bus.tx_ready = 1'b1;
    repeat (5) tick();
    expq = '{8'hA5};
    check_txq("ovf");
    check("ovf_sticky", 32'(bus.rx_ovf), 32'd1);

    // Reset during banner idx10, then a full restart
    wait_byte("rst_idx10", 8'h58, 250);
    rst = 1'b1;
    #1;
    check("midrst_vld", 32'(bus.tx_valid),   32'd0);
    check("midrst_act", 32'(bus.banner_act), 32'd0);
    check("midrst_ovf", 32'(bus.rx_ovf),     32'd0);
    tick();
    rst = 1'b0;
    txq.delete();
    wait_vld("ban2", 200, cyc);
    check("ban2_latency", 32'(cyc),         32'd102);
    check("ban2_first",   32'(bus.tx_data), 32'h48);
    repeat (42) tick();
    expq.delete();
    foreach (rom_exp[i]) expq.push_back(rom_exp[i]);
    check_txq("ban2");

    // RX every 3 cycles
    txq.delete();
    expq = '{8'h01, 8'h7F, 8'h80, 8'hFF, 8'hC3, 8'h3C};
    foreach (expq[i]) begin
      rx_byte(expq[i]);
      tick();
      tick();
    end
    repeat (5) tick();
    check_txq("b2b3");
    check("b2b3_ovf", 32'(bus.rx_ovf), 32'd0);

    // RX every 2 cycles: reload on the transfer edge
    txq.delete();
    expq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    foreach (expq[i]) begin
      rx_byte(expq[i]);
      tick();
    end
    repeat (6) tick();
    check_txq("b2b2");
    check("b2b2_ovf", 32'(bus.rx_ovf), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
